// File: rtl/seg7_scan_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_reader                                                |
// | Purpose  : Rebuilds BCD digits from a scanned 7-segment bus, with a glitch |
// |            filter and a valid/ack frame handshake.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_scan_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic              frame_ack,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   digit_err,
  output logic              frame_valid,
  output logic              overrun
);

  localparam int          c_cw     = $clog2(STABLE + 1);
  localparam logic [c_cw-1:0] c_stable = c_cw'(STABLE);
  localparam logic [c_cw-1:0] c_one    = c_cw'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
  logic              w_cap;

  logic [6:0]        r_s_seg, r_p_seg;
  logic [NDIG-1:0]   r_s_sel, r_p_sel;
  logic [4*NDIG-1:0] r_slot;
  logic [NDIG-1:0]   r_slot_err;
  logic [NDIG-1:0]   r_seen;
  logic [4*NDIG-1:0] r_bcd;
  logic [NDIG-1:0]   r_derr;
  logic              r_valid;
  logic              r_ovr;

  logic              w_onehot;
  logic              w_same;
  logic [4:0]        w_dec;
  logic [NDIG-1:0]   w_cap_mask;
  logic [NDIG-1:0]   w_seen_nxt;
  logic              w_done;
  logic [4*NDIG-1:0] w_bcd_nxt;
  logic [NDIG-1:0]   w_err_nxt;

  // Returns {err, value}; anything outside the ten digit shapes reads as F.
  function automatic logic [4:0] f_decode(input logic [6:0] p);
    case (p)
      7'b1111110: f_decode = 5'b0_0000;
      7'b0110000: f_decode = 5'b0_0001;
      7'b1101101: f_decode = 5'b0_0010;
      7'b1111001: f_decode = 5'b0_0011;
      7'b0110011: f_decode = 5'b0_0100;
      7'b1011011: f_decode = 5'b0_0101;
      7'b1011111: f_decode = 5'b0_0110;
      7'b1110000: f_decode = 5'b0_0111;
      7'b1111111: f_decode = 5'b0_1000;
      7'b1111011: f_decode = 5'b0_1001;
      default:    f_decode = 5'b1_1111;
    endcase
  endfunction

  assign w_onehot   = (r_s_sel != '0) && ((r_s_sel & (r_s_sel - NDIG'(1))) == '0);
  assign w_same     = ({r_s_sel, r_s_seg} == {r_p_sel, r_p_seg});
  assign w_dec      = f_decode(r_s_seg);
  assign w_cap_mask = w_cap ? r_s_sel : '0;
  assign w_seen_nxt = r_seen | w_cap_mask;
  assign w_done     = &w_seen_nxt;

  // Frame contents as they will be after this cycle's capture, so the last
  // digit can complete the frame without an extra cycle of latency.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_next
    assign w_bcd_nxt[4*gi +: 4] = w_cap_mask[gi] ? w_dec[3:0] : r_slot[4*gi +: 4];
    assign w_err_nxt[gi]        = w_cap_mask[gi] ? w_dec[4]   : r_slot_err[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_nxt = TRACK;
          w_cnt_nxt   = c_one;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      TRACK: begin
        if (!w_onehot) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_same) begin
          if (r_cnt >= c_stable - c_one) begin
            w_cnt_nxt   = c_stable;
            w_cap       = 1'b1;
            w_state_nxt = LOCKED;
          end else begin
            w_cnt_nxt   = r_cnt + c_one;
          end
        end else begin
          w_cnt_nxt = c_one;
        end
      end
      LOCKED: begin
        if (!w_onehot) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (!w_same) begin
          w_state_nxt = TRACK;
          w_cnt_nxt   = c_one;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_seg <= '0;
      r_s_sel <= '0;
      r_p_seg <= '0;
      r_p_sel <= '0;
    end else begin
      r_s_seg <= seg_in;
      r_s_sel <= dig_sel;
      r_p_seg <= r_s_seg;
      r_p_sel <= r_s_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot     <= '0;
      r_slot_err <= '0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (w_cap_mask[i]) begin
          r_slot[4*i +: 4] <= w_dec[3:0];
          r_slot_err[i]    <= w_dec[4];
        end
      end
    end
  end

  // A completing frame always wins over an ack; overrun flags a lost frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen  <= '0;
      r_bcd   <= '0;
      r_derr  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_done) begin
      r_seen  <= '0;
      r_bcd   <= w_bcd_nxt;
      r_derr  <= w_err_nxt;
      r_valid <= 1'b1;
      if (r_valid && !frame_ack) begin
        r_ovr <= 1'b1;
      end
    end else begin
      r_seen <= w_seen_nxt;
      if (r_valid && frame_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bcd_out     = r_bcd;
  assign digit_err   = r_derr;
  assign frame_valid = r_valid;
  assign overrun     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg7_scan_reader                                             |
// | Purpose  : Scoreboard bench for seg7_scan_reader against a run-length model.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_reader;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [6:0]        seg_in = '0;
  logic [NDIG-1:0]   dig_sel = '0;
  logic              frame_ack = 1'b0;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   digit_err;
  logic              frame_valid;
  logic              overrun;

  seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
    .frame_ack(frame_ack), .bcd_out(bcd_out), .digit_err(digit_err),
    .frame_valid(frame_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [15:0]   bcd;
    logic [3:0]    err;
  } ev_t;

  ev_t        q[$];
  logic [6:0] pat [10];
  int         checks = 0;
  int         failures = 0;

  // Reference model: a digit is taken once a one-hot sample repeats STABLE times.
  logic [10:0] m_prev;
  int          m_run = 0;
  logic [15:0] m_bcdv = '0;
  logic [3:0]  m_errv = '0;
  logic [3:0]  m_seen = '0;
  bit          m_pend = 0;
  bit          m_ovr = 0;
  bit          auto_ack = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic [3:0] sel, input logic [6:0] seg);
    int idx;
    logic [3:0] val;
    logic e;
    if ($countones(sel) != 1) m_run = 0;
    else if (m_run > 0 && {sel, seg} == m_prev) m_run++;
    else m_run = 1;
    m_prev = {sel, seg};
    if (m_run == STABLE) begin
      idx = 0;
      for (int i = 0; i < NDIG; i++) if (sel[i]) idx = i;
      val = 4'hF;
      e = 1'b1;
      for (int k = 0; k < 10; k++) if (pat[k] == seg) begin val = 4'(k); e = 1'b0; end
      m_bcdv[4*idx +: 4] = val;
      m_errv[idx] = e;
      m_seen[idx] = 1'b1;
      if (&m_seen) begin
        q.push_back('{cyc: cyc + 2, bcd: m_bcdv, err: m_errv});
        m_seen = '0;
      end
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      dig_sel = sel;
      seg_in  = seg;
      model_step(sel, seg);
    end
  endtask

  task automatic scan4(input int d3, input int d2, input int d1, input int d0, input int hold);
    drive(4'b1000, pat[d3], hold);
    drive(4'b0100, pat[d2], hold);
    drive(4'b0010, pat[d1], hold);
    drive(4'b0001, pat[d0], hold);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || m_pend) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {31'd0, (q.size() > 0 || m_pend)}, 32'd0);
  endtask

  // Monitor: pops the expected frame on its due cycle, tracks valid/overrun.
  always @(negedge clk) begin : monitor
    ev_t  e;
    logic acked;
    acked = frame_ack;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("frame_late", 32'(cyc), 32'(e.cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      if (m_pend && !acked) m_ovr = 1;
      m_pend = 1;
      chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
      chk("digit_err", 32'(digit_err), 32'(e.err));
    end else if (acked) begin
      m_pend = 0;
    end
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_pend});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    frame_ack = auto_ack ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial begin
    int r, hold;
    logic [3:0] sel;
    logic [6:0] seg;
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101;
    pat[3] = 7'b1111001; pat[4] = 7'b0110011; pat[5] = 7'b1011011;
    pat[6] = 7'b1011111; pat[7] = 7'b1110000; pat[8] = 7'b1111111;
    pat[9] = 7'b1111011;
    m_prev = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_bcd", 32'(bcd_out), 32'd0);
    chk("reset_err", 32'(digit_err), 32'd0);
    rst = 1'b0;

    // Clean scan: 1,9,5,0 on digits 3..0.
    scan4(1, 9, 5, 0, 6);
    drive(4'b0000, 7'd0, 3);
    drain();

    // Glitch filter on digit 2, then short holds that must never capture.
    drive(4'b1000, pat[7], 5);
    drive(4'b0100, pat[2], 2);
    drive(4'b0100, pat[3], 4);
    drive(4'b0010, pat[6], 4);
    drive(4'b0001, pat[8], 4);
    drain();
    for (int k = 0; k < 2; k++) scan4(4, 4, 2, 1, STABLE - 1);
    drive(4'b0000, 7'd0, 3);
    drain();

    // Illegal code on digit 1.
    drive(4'b1000, pat[2], 4);
    drive(4'b0100, pat[0], 4);
    drive(4'b0010, 7'b1000000, 5);
    drive(4'b0001, pat[9], 4);
    drain();

    // Non-one-hot select in the middle of a scan.
    drive(4'b1000, pat[3], 4);
    drive(4'b0100, pat[5], 4);
    drive(4'b0110, pat[8], 10);
    drive(4'b0000, pat[8], 10);
    drive(4'b0010, pat[1], 4);
    drive(4'b0001, pat[7], 4);
    drain();

    // Overrun: second frame lands unacked.
    auto_ack = 0;
    @(negedge clk);
    scan4(8, 7, 6, 5, 4);
    scan4(4, 3, 2, 1, 4);
    drive(4'b0000, 7'd0, 4);
    chk("ovr_bcd", 32'(bcd_out), 32'h4321);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    auto_ack = 1;
    drain();

    // Reset in the middle of the last digit's tracking.
    drive(4'b0001, pat[1], 4);
    drive(4'b0010, pat[2], 4);
    drive(4'b0100, pat[3], 4);
    drive(4'b1000, pat[4], 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    m_pend = 0; m_ovr = 0; m_seen = '0; m_run = 0; m_prev = '0;
    dig_sel = '0; seg_in = '0;
    #1;
    chk("arst_bcd", 32'(bcd_out), 32'd0);
    chk("arst_valid", {31'd0, frame_valid}, 32'd0);
    chk("arst_ovr", {31'd0, overrun}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b1000, pat[4], 4);
    drive(4'b0000, 7'd0, 4);
    scan4(6, 0, 2, 7, 4);
    drain();

    // Randomised scanning with random acks.
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      hold = $urandom_range(1, 6);
      if (r == 0) begin
        sel = 4'($urandom_range(0, 15));
        if ($countones(sel) == 1) sel = 4'b0000;
      end else begin
        sel = 4'b0001 << $urandom_range(0, 3);
      end
      seg = (r == 1) ? 7'($urandom) : pat[$urandom_range(0, 9)];
      drive(sel, seg, hold);
    end
    drive(4'b0000, 7'd0, 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Reader end of the team's BCD-to-7-segment display path: watches a multiplexed, scanned 7-segment bus (segment lines plus one-hot digit select) and reconstructs the displayed BCD digits.
- Filters scan glitches by requiring a stable pattern before capture, then inverse-decodes each pattern to BCD.
- Delivers a complete multi-digit frame through a valid/ack handshake.
- Used for display loop-back checking and self-test next to the segment decoder.

Parameters:
- NDIG, 4, number of scanned digits (width of dig_sel); legal range 1..8.
- STABLE, 3, consecutive identical samples required before a digit is captured; legal range 2..15.

Ports:
- clk  input  1  single system clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines {a,b,c,d,e,f,g}; bit6=a, bit0=g; active-high (1 = lit).
- dig_sel  input  NDIG  digit select, one-hot, active-high; bit i = digit i, where digit 0 is the least significant.
- frame_ack  input  1  consumer accepts the current frame; sampled only while frame_valid=1.
- bcd_out  output  4*NDIG  captured frame; bits [4i+3:4i] = digit i.
- digit_err  output  NDIG  per-digit flag: captured pattern was not a legal 0-9 code.
- frame_valid  output  1  frame available; held until acked.
- overrun  output  1  sticky flag: a new frame completed while the previous one was still unacked.

Behaviour:
- Reset (async, immediate):
  - bcd_out=0, digit_err=0, frame_valid=0, overrun=0.
  - Input registers, slot registers, seen mask and stable counter cleared; FSM goes to IDLE.
- Input stage: seg_in and dig_sel are registered every cycle (s_seg, s_sel). All decisions use the registered values, giving 1 cycle of input latency.
- Legal code table, 7-bit pattern -> BCD:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - Any other pattern -> value 4'hF with err=1.
- FSM states: IDLE, TRACK, LOCKED.
  - IDLE: entered whenever s_sel is zero or not one-hot. Counter cleared. Leaves to TRACK with cnt=1 when s_sel becomes one-hot.
  - TRACK: if {s_sel,s_seg} equals the previous cycle's sample, cnt increments; otherwise cnt=1 and the FSM stays in TRACK, or goes to IDLE if s_sel is not one-hot.
  - TRACK capture: when cnt reaches STABLE, that cycle writes slot[i] and err[i] for the selected digit i, sets seen[i], and moves to LOCKED.
  - LOCKED: holds while the sample is unchanged; no further captures. Any change in s_sel or s_seg goes to TRACK with cnt=1 (or IDLE if s_sel is not one-hot). A segment change under the same select therefore re-captures the same digit.
- Counter saturates at STABLE; width is clog2(STABLE+1).
- Frame completion:
  - On the cycle after seen becomes all ones, bcd_out/digit_err are loaded from the slots, frame_valid=1 and seen is cleared.
  - The capture of the last digit on cycle N gives frame_valid=1 on cycle N+1.
  - A slot rewritten before the frame completes keeps the newest value.
- Handshake:
  - frame_valid stays high with bcd_out/digit_err frozen until a cycle with frame_ack=1, after which frame_valid=0 next cycle.
  - frame_ack while frame_valid=0 is ignored.
- Simultaneous events:
  - If a new frame completes on the same cycle frame_ack is high, the new frame loads, frame_valid stays 1 and overrun is unchanged.
  - If a new frame completes while frame_valid=1 and frame_ack=0, the outputs are overwritten and overrun is set.
  - overrun clears only on rst.
- Reset mid-operation discards partial frame, slots and any pending frame_valid.

Test Plan:
- Clean scan, NDIG=4, STABLE=3: each digit held 6 cycles, digits 3..0 show patterns for 1,9,5,0 -> one cycle after the last capture, frame_valid=1, bcd_out=16'h1950, digit_err=4'b0000.
- Glitch filter: digit 2 shows 1101101 for 2 cycles, then 1111001 for 4 cycles -> slot2=3 only. A pattern held for exactly STABLE-1=2 cycles never captures, and no frame completes.
- Illegal code: digit 1 shows 1000000 for 5 cycles, other digits legal -> bcd_out[7:4]=4'hF, digit_err=4'b0010.
- Handshake/overrun: complete a frame, hold frame_ack=0, complete a second frame with value 16'h4321 -> bcd_out=16'h4321, overrun=1. Pulse frame_ack -> frame_valid=0 next cycle, overrun stays 1.
- Non-one-hot select: dig_sel=4'b0110 or 4'b0000 for 10 cycles -> FSM in IDLE, no slot writes, seen unchanged.
- Async reset asserted mid-TRACK with 3 of 4 digits seen -> outputs 0 immediately. After release, a full new scan is needed before frame_valid.
